// File: rtl/mdu_hilo.sv
// Multiply/divide unit that owns the architectural HI/LO registers.
// Results are computed at launch and committed after a fixed busy latency.
module mdu_hilo #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        RSel,
    output logic [31:0] RData,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy,
    output logic        Stall
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   phi_q, phi_d, plo_q, plo_d;
    logic          pwr_q, pwr_d;

    logic is_mul, is_div, is_long;
    assign is_mul  = (MDUOp == 3'd1) || (MDUOp == 3'd2);
    assign is_div  = (MDUOp == 3'd3) || (MDUOp == 3'd4);
    assign is_long = is_mul || is_div;

    // Low 64 bits of a product of sign-extended operands equal the signed product.
    logic [63:0] prod_s, prod_u;
    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Divisor forced nonzero so the dividers never see zero; the result is discarded then.
    logic [31:0] b_nz, a_mag, b_mag, sq_mag, sr_mag, sq, sr, uq, ur;
    assign b_nz   = (B == 32'd0) ? 32'd1 : B;
    assign a_mag  = A[31] ? (32'd0 - A) : A;
    assign b_mag  = B[31] ? (32'd0 - b_nz) : b_nz;
    assign sq_mag = a_mag / b_mag;
    assign sr_mag = a_mag % b_mag;
    assign sq     = (A[31] ^ B[31]) ? (32'd0 - sq_mag) : sq_mag;
    assign sr     = A[31] ? (32'd0 - sr_mag) : sr_mag;
    assign uq     = A / b_nz;
    assign ur     = A % b_nz;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            phi_q   <= '0;
            plo_q   <= '0;
            pwr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
            pwr_q   <= pwr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        pwr_d   = pwr_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    if (is_long) begin
                        state_d = S_RUN;
                        cnt_d   = is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                        pwr_d   = !(is_div && (B == 32'd0));
                    end
                    case (MDUOp)
                        3'd1: {phi_d, plo_d} = prod_s;
                        3'd2: {phi_d, plo_d} = prod_u;
                        3'd3: begin phi_d = sr; plo_d = sq; end
                        3'd4: begin phi_d = ur; plo_d = uq; end
                        3'd5: hi_d = A;
                        3'd6: lo_d = A;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_IDLE;
                    if (pwr_q) begin
                        hi_d = phi_q;
                        lo_d = plo_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        Busy  = (state_q == S_RUN);
        Stall = Busy || (Start && is_long);
        HI    = hi_q;
        LO    = lo_q;
        RData = RSel ? lo_q : hi_q;
    end

endmodule

// File: tb/tb_mdu_hilo.sv
// Randomized and directed bench for mdu_hilo against a timestamp-based reference model.
module tb_mdu_hilo;
    localparam int ML = 5;
    localparam int DL = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Start = 1'b0;
    logic [2:0]  MDUOp = 3'd0;
    logic [31:0] A = '0, B = '0;
    logic        RSel = 1'b0;
    logic [31:0] RData, HI, LO;
    logic        Busy, Stall;

    int checks = 0;
    int errors = 0;

    mdu_hilo #(.MULT_CYCLES(ML), .DIV_CYCLES(DL)) dut (
        .clk(clk), .reset(reset), .Start(Start), .MDUOp(MDUOp), .A(A), .B(B),
        .RSel(RSel), .RData(RData), .HI(HI), .LO(LO), .Busy(Busy), .Stall(Stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an op accepted at edge k commits at edge done_cyc = k + latency;
    // the unit is busy after every edge strictly before done_cyc.
    int          cyc = 0;
    int          done_cyc = -1;
    bit          m_valid = 0;
    bit          pend_wr;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;

    always @(posedge clk) begin
        int sa, sb;
        longint p, q, r;
        longint unsigned pu;
        cyc++;
        sa = A;
        sb = B;
        if (reset) begin
            m_hi = '0; m_lo = '0; done_cyc = -1; pend_wr = 0; m_valid = 1;
        end else if (m_valid) begin
            if (cyc < done_cyc) begin
                // in flight: every request is ignored
            end else if (cyc == done_cyc) begin
                if (pend_wr) begin m_hi = p_hi; m_lo = p_lo; end
            end else if (Start) begin
                case (MDUOp)
                    3'd1: begin
                        p = longint'(sa) * longint'(sb);
                        p_hi = p[63:32]; p_lo = p[31:0]; pend_wr = 1; done_cyc = cyc + ML;
                    end
                    3'd2: begin
                        pu = A; pu = pu * B;
                        p_hi = pu[63:32]; p_lo = pu[31:0]; pend_wr = 1; done_cyc = cyc + ML;
                    end
                    3'd3: begin
                        pend_wr = (B != 0);
                        if (pend_wr) begin
                            q = longint'(sa) / longint'(sb);
                            r = longint'(sa) % longint'(sb);
                            p_lo = q[31:0]; p_hi = r[31:0];
                        end
                        done_cyc = cyc + DL;
                    end
                    3'd4: begin
                        pend_wr = (B != 0);
                        if (pend_wr) begin p_lo = A / B; p_hi = A % B; end
                        done_cyc = cyc + DL;
                    end
                    3'd5: m_hi = A;
                    3'd6: m_lo = A;
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("Busy", {31'd0, Busy}, {31'd0, cyc < done_cyc});
            chk("Stall", {31'd0, Stall},
                {31'd0, (cyc < done_cyc) || (Start && MDUOp >= 3'd1 && MDUOp <= 3'd4)});
            chk("HI", HI, m_hi);
            chk("LO", LO, m_lo);
            chk("RData", RData, RSel ? m_lo : m_hi);
        end
    end

    task automatic step(input bit st, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        #1;
        Start = st; MDUOp = op; A = a; B = b;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 3'd0, 32'd0, 32'd0);
    endtask

    // Launch, wait out the latency, and land on the first negedge with Busy low.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int lat);
        step(1, op, a, b);
        idle(lat);
        @(negedge clk);
    endtask

    initial begin
        idle(3);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst HI", HI, 32'd0);
        chk("rst LO", LO, 32'd0);
        chk("rst Busy", {31'd0, Busy}, 32'd0);
        chk("rst RData hi", RData, 32'd0);
        #1 RSel = 1'b1;
        #1 chk("rst RData lo", RData, 32'd0);
        RSel = 1'b0;

        run_op(3'd1, 32'hFFFFFFFE, 32'd3, ML);
        chk("mult HI", HI, 32'hFFFFFFFF);
        chk("mult LO", LO, 32'hFFFFFFFA);
        chk("mult Busy", {31'd0, Busy}, 32'd0);
        run_op(3'd2, 32'hFFFFFFFE, 32'd3, ML);
        chk("multu HI", HI, 32'h00000002);
        chk("multu LO", LO, 32'hFFFFFFFA);
        run_op(3'd3, 32'hFFFFFFF9, 32'd2, DL);
        chk("div LO", LO, 32'hFFFFFFFD);
        chk("div HI", HI, 32'hFFFFFFFF);

        step(1, 3'd5, 32'h11, 32'd0);
        step(1, 3'd6, 32'h22, 32'd0);
        run_op(3'd4, 32'd7, 32'd0, DL);
        chk("divu0 HI", HI, 32'h11);
        chk("divu0 LO", LO, 32'h22);

        step(1, 3'd5, 32'hDEADBEEF, 32'd0);
        step(1, 3'd6, 32'h12345678, 32'd0);
        @(negedge clk);
        chk("mthi HI", HI, 32'hDEADBEEF);
        chk("mtlo LO", LO, 32'h12345678);
        #1 RSel = 1'b1;
        #1 chk("mflo RData", RData, 32'h12345678);

        run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, DL);
        chk("divovf LO", LO, 32'h80000000);
        chk("divovf HI", HI, 32'h00000000);

        step(1, 3'd1, 32'hFFFFFFFE, 32'd3);
        step(1, 3'd5, 32'h0000AAAA, 32'd0);
        idle(4);
        @(negedge clk);
        chk("mthi-ignored HI", HI, 32'hFFFFFFFF);

        // mthi on the commit edge is dropped; the next mult is accepted right after
        step(1, 3'd1, 32'd3, 32'd4);
        idle(4);
        step(1, 3'd5, 32'h5555, 32'd0);
        step(1, 3'd1, 32'd5, 32'd6);
        idle(ML);
        @(negedge clk);
        chk("b2b HI", HI, 32'd0);
        chk("b2b LO", LO, 32'd30);

        step(1, 3'd3, 32'hFFFFFFF9, 32'd2);
        idle(2);
        @(negedge clk);
        #1 reset = 1'b1; Start = 1'b0;
        @(negedge clk);
        chk("abort Busy", {31'd0, Busy}, 32'd0);
        chk("abort HI", HI, 32'd0);
        chk("abort LO", LO, 32'd0);
        #1 reset = 1'b0;
        idle(DL + 2);
        @(negedge clk);
        chk("abort late HI", HI, 32'd0);
        chk("abort late LO", LO, 32'd0);

        repeat (600) begin
            logic [31:0] a, b;
            @(negedge clk);
            #1;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 15))
                0, 1: b = 32'd0;
                2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                3: b = $urandom_range(1, 9);
                default: ;
            endcase
            reset = ($urandom_range(0, 79) == 0);
            Start = $urandom_range(0, 1);
            MDUOp = 3'($urandom_range(0, 7));
            A = a; B = b;
            RSel = $urandom_range(0, 1);
        end
        #1 reset = 1'b0;
        idle(DL + 2);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Multiply/divide unit owning the HI and LO registers.
- Accepts mult/multu/div/divu operands read from the GRF. Runs a fixed-latency multi-cycle operation, then sources HI/LO back toward GRF write-back for mfhi/mflo.
- Also services mthi/mtlo.
- Sits beside the ALU in the execute stage. Its Busy/Stall outputs feed the CPU stall logic.

Parameters:
- MULT_CYCLES, 5, cycles Busy stays high for mult/multu (must be >= 1)
- DIV_CYCLES, 10, cycles Busy stays high for div/divu (must be >= 1)

Ports:
- clk  input  1  system clock; all state updates on posedge
- reset  input  1  synchronous, active-high reset
- Start  input  1  request to launch/execute the operation on MDUOp this cycle
- MDUOp  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- A  input  32  operand rs (dividend / multiplicand / mthi-mtlo source)
- B  input  32  operand rt (divisor / multiplier)
- RSel  input  1  read select: 0 = HI, 1 = LO (mfhi/mflo)
- RData  output  32  combinational: HI when RSel=0, else LO
- HI  output  32  architectural HI register
- LO  output  32  architectural LO register
- Busy  output  1  registered; high while an operation is in flight
- Stall  output  1  combinational: Busy OR (Start AND MDUOp in {1,2,3,4}); for hazard logic

Behaviour:
- Reset (sync, active-high, checked first each posedge):
  - HI=0, LO=0, Busy=0, cycle counter=0, pending results=0.
  - A reset mid-operation aborts it. No HI/LO update ever occurs from the aborted op.
- States:
  - IDLE (Busy=0) and RUN (Busy=1).
  - Down-counter cnt, width ceil(log2(max(MULT_CYCLES, DIV_CYCLES)+1)).
- IDLE:
  - Start with MDUOp 1..4: result computed from A, B at this edge and held in internal regs (pHI, pLO). cnt loads MULT_CYCLES or DIV_CYCLES. Next state RUN.
  - Start with MDUOp 5: HI<=A at this edge; Busy stays 0.
  - Start with MDUOp 6: LO<=A at this edge; Busy stays 0.
  - Start with MDUOp 0 or 7, or Start=0: no change.
- RUN:
  - cnt decrements each cycle. HI/LO keep their old values while Busy=1.
  - On the cycle cnt==1: HI<=pHI, LO<=pLO, Busy<=0, state IDLE.
  - Busy is high for exactly MULT_CYCLES/DIV_CYCLES cycles after the accepting edge.
  - New HI/LO are visible the same cycle Busy first reads 0.
  - Any Start during RUN, including mthi/mtlo, is ignored. The CPU must hold the instruction via Stall.
- Arithmetic:
  - mult: signed 32x32->64. HI = product[63:32], LO = product[31:0].
  - multu: same, unsigned.
  - div: signed. LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (no trap).
  - Divide by zero (B==0, div or divu): operation still runs the full DIV_CYCLES, but HI and LO are left unchanged at completion.
- Back-to-back: Start for a new mult/div is accepted in the same cycle Busy reads 0. HI/LO from the previous op are already committed. The new op then runs its full latency.
- RData and the HI/LO outputs are purely combinational from the registers; no read latency.

Test Plan:
- Reset then idle: after reset, HI=0, LO=0, Busy=0. RData=0 for both RSel.
- mult A=0xFFFFFFFE (-2), B=3:
  - Busy is high for exactly 5 cycles.
  - HI/LO stay 0 throughout.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - multu with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- div A=0xFFFFFFF9 (-7), B=2:
  - After 10 Busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu A=7, B=0 with HI=0x11, LO=0x22 preloaded via mthi/mtlo -> after 10 cycles HI=0x11, LO=0x22.
- mthi A=0xDEADBEEF, then mtlo A=0x12345678 on consecutive cycles:
  - HI and LO update at each edge; Busy stays 0.
  - RSel=1 gives RData=0x12345678.
- Start mthi A=0xAAAA during a running mult: ignored. HI ends as the mult result. Stall=1 throughout Busy.
- Reset asserted in Busy cycle 3 of a div: next cycle Busy=0, HI=LO=0. No late update follows in any later cycle.
